// File: rtl/reg_display_scanner_pkg.sv
// Shared constants for the LED bank display scanner: glyph table, blank
// patterns and the scan state encoding.
package reg_display_scanner_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/reg_display_scanner_seg7_decoder.sv
// Combinational 3-bit value to active-low seven-segment glyph.
module seg7_decoder
  import reg_display_scanner_pkg::*;
(
  input  logic [2:0] val_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (val_i)
      3'd0: seg_o = GLYPH_0;
      3'd1: seg_o = GLYPH_1;
      3'd2: seg_o = GLYPH_2;
      3'd3: seg_o = GLYPH_3;
      3'd4: seg_o = GLYPH_4;
      3'd5: seg_o = GLYPH_5;
      3'd6: seg_o = GLYPH_6;
      3'd7: seg_o = GLYPH_7;
    endcase
  end

endmodule

// File: rtl/reg_display_scanner.sv
// Shows the snapshotted LED bank registers and the load count on a
// 4-digit multiplexed seven-segment display, blanking at each slot start.
module reg_display_scanner
  import reg_display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] bank0,
  input  logic [2:0] bank1,
  input  logic       active_bank,
  input  logic       load,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int               CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DRIVE = CNT_W'(BLANK_CYCLES);

  logic             load_q;
  logic [2:0]       shadow0_q, shadow1_q, load_cnt_q;
  logic             shadow_act_q;
  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dig_q, dig_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [2:0]       dec_val;
  logic [6:0]       dec_seg;
  logic             load_rise;

  assign load_rise = load & ~load_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      load_q       <= 1'b0;
      shadow0_q    <= 3'd0;
      shadow1_q    <= 3'd0;
      shadow_act_q <= 1'b0;
      load_cnt_q   <= 3'd0;
    end else begin
      load_q <= load;
      if (load_rise) begin
        shadow0_q    <= bank0;
        shadow1_q    <= bank1;
        shadow_act_q <= active_bank;
        load_cnt_q   <= load_cnt_q + 3'd1;
      end
    end
  end

  // state_q tracks the phase of the current cnt_q value, so DRIVE means cnt_q >= BLANK_CYCLES
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      dig_q   <= 2'd0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    dig_d   = dig_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      state_d = ST_BLANK;
      dig_d   = dig_q + 2'd1;
    end else if (cnt_d == CNT_DRIVE) begin
      state_d = ST_DRIVE;
    end
  end

  always_comb begin
    dec_val = 3'd0;
    case (dig_q)
      2'd0:    dec_val = shadow0_q;
      2'd1:    dec_val = shadow1_q;
      default: dec_val = load_cnt_q;
    endcase
  end

  seg7_decoder u_dec (
    .val_i (dec_val),
    .seg_o (dec_seg)
  );

  // Shadows are read here, so a snapshot reaches the pins one edge after capture
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (state_q == ST_DRIVE) begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = (dig_q == 2'd3) ? SEG_BLANK : dec_seg;
      dp_d  = ~(~dig_q[1] & (dig_q[0] == shadow_act_q));
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
